// File: rtl/data_stack.sv
// -----------------------------------------------------------------------------
// data_stack
//   Operand stack of the 16-bit stack CPU. The two topmost entries live in
//   registers and feed the ALU directly (tos -> operand b, nos -> operand a).
//   Entries below them spill into an internal array of DEPTH-2 words.
//   One stack operation is accepted per clock. Every output is registered.
//
// Ports
//   clk    in   1                rising-edge clock
//   reset  in   1                synchronous, active-high reset
//   op     in   2                00 NOP, 01 PUSH, 10 POP, 11 BINOP
//   din    in   WIDTH            value for PUSH, or ALU result for BINOP
//   tos    out  WIDTH            top entry (0 when count==0)
//   nos    out  WIDTH            second entry (0 when count<=1)
//   count  out  $clog2(DEPTH+1)  number of valid entries
//   empty  out  1                count==0
//   full   out  1                count==DEPTH
//   err    out  1                sticky, set by any illegal op until reset
// -----------------------------------------------------------------------------
module data_stack #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 32,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             err
);

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_PUSH  = 2'b01,
    OP_POP   = 2'b10,
    OP_BINOP = 2'b11
  } op_e;

  localparam int SPILL_DEPTH = DEPTH - 2;
  // Index width of the spill array; kept at least 1 bit for DEPTH==3.
  localparam int SW = (SPILL_DEPTH > 1) ? $clog2(SPILL_DEPTH) : 1;

  logic [WIDTH-1:0] spill [SPILL_DEPTH];

  op_e              op_q;
  logic             do_push;
  logic             do_pop;
  logic             do_binop;
  logic             illegal;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    wr_full_idx;
  logic [CW-1:0]    rd_full_idx;
  logic [SW-1:0]    wr_idx;
  logic [SW-1:0]    rd_idx;
  logic [WIDTH-1:0] spill_top;

  assign op_q = op_e'(op);

  // Decode legality and compute the next count and spill addresses from the
  // pre-edge count.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_binop   = 1'b0;
    illegal    = 1'b0;
    count_next = count;

    unique case (op_q)
      OP_NOP: ;
      OP_PUSH: begin
        if (full) illegal = 1'b1;
        else      do_push = 1'b1;
      end
      OP_POP: begin
        if (empty) illegal = 1'b1;
        else       do_pop  = 1'b1;
      end
      OP_BINOP: begin
        if (count < CW'(2)) illegal  = 1'b1;
        else                do_binop = 1'b1;
      end
      default: ;
    endcase

    if (do_push)               count_next = count + CW'(1);
    else if (do_pop || do_binop) count_next = count - CW'(1);

    // PUSH writes entry count-2 (old nos); POP/BINOP refill nos from entry
    // count-3. The ranges used never exceed the array, so truncation is safe.
    wr_full_idx = count - CW'(2);
    rd_full_idx = count - CW'(3);
  end

  assign wr_idx = wr_full_idx[SW-1:0];
  assign rd_idx = rd_full_idx[SW-1:0];

  // Asynchronous read of the deepest-but-two entry; zero when nothing is
  // spilled so nos zero-fills on the way down.
  assign spill_top = (count >= CW'(3)) ? spill[rd_idx] : '0;

  // NOTE: the spill array is deliberately left out of reset; count alone
  // decides which entries are valid, and skipping the clear keeps the array
  // mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (!reset && do_push && (count >= CW'(2))) begin
      spill[wr_idx] <= nos;
    end
  end

  // Register slots and status flags.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      tos   <= '0;
      nos   <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (do_push) begin
        nos <= tos;
        tos <= din;
      end else if (do_pop) begin
        tos <= nos;
        nos <= spill_top;
      end else if (do_binop) begin
        tos <= din;
        nos <= spill_top;
      end

      if (illegal) err <= 1'b1;

      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_data_stack.sv
// -----------------------------------------------------------------------------
// tb_data_stack
//   Self-checking bench for data_stack. A queue-based reference model holds
//   the whole stack; tos/nos/count/flags are derived from it and compared
//   against the DUT on every falling edge. Directed sequences with literal
//   expectations pin the model, then randomized traffic exercises the rest.
// -----------------------------------------------------------------------------
module tb_data_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [1:0] NOP   = 2'b00;
  localparam logic [1:0] PUSH  = 2'b01;
  localparam logic [1:0] POP   = 2'b10;
  localparam logic [1:0] BINOP = 2'b11;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       op;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             err;

  int n_cmp  = 0;
  int n_fail = 0;
  bit armed  = 1'b0;

  // Reference model: whole stack as a queue, back = top.
  logic [WIDTH-1:0] mq[$];
  bit               m_err = 1'b0;

  data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .din   (din),
    .tos   (tos),
    .nos   (nos),
    .count (count),
    .empty (empty),
    .full  (full),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_tos();
    return (mq.size() >= 1) ? mq[mq.size()-1] : '0;
  endfunction

  function automatic logic [WIDTH-1:0] m_nos();
    return (mq.size() >= 2) ? mq[mq.size()-2] : '0;
  endfunction

  task automatic model_apply(input logic [1:0] o, input logic [WIDTH-1:0] d,
                             input logic r);
    if (r) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      case (o)
        PUSH:  if (mq.size() < DEPTH) mq.push_back(d); else m_err = 1'b1;
        POP:   if (mq.size() >= 1) void'(mq.pop_back()); else m_err = 1'b1;
        BINOP: if (mq.size() >= 2) begin
                 void'(mq.pop_back());
                 void'(mq.pop_back());
                 mq.push_back(d);
               end else m_err = 1'b1;
        default: ;
      endcase
    end
  endtask

  // Drive one op, let it be sampled, update the model, settle away from edge.
  task automatic step(input logic [1:0] o, input logic [WIDTH-1:0] d,
                      input logic r = 1'b0);
    op    = o;
    din   = d;
    reset = r;
    @(posedge clk);
    model_apply(o, d, r);
    #1;
    if (r) armed = 1'b1;
  endtask

  // Continuous model comparison on every falling edge once reset has been seen.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        check("tos",   32'(tos),   32'(m_tos()));
        check("nos",   32'(nos),   32'(m_nos()));
        check("count", 32'(count), 32'(mq.size()));
        check("empty", 32'(empty), 32'(mq.size() == 0));
        check("full",  32'(full),  32'(mq.size() == DEPTH));
        check("err",   32'(err),   32'(m_err));
      end
    end
  end

  initial begin
    int push_pct;
    int x;
    op = NOP; din = '0; reset = 1'b1;

    // 1. reset then idle
    step(NOP, 0, 1'b1);
    repeat (3) step(NOP, 0);
    check("t1_tos", 32'(tos), 0);
    check("t1_nos", 32'(nos), 0);
    check("t1_count", 32'(count), 0);
    check("t1_empty", 32'(empty), 1);
    check("t1_full", 32'(full), 0);
    check("t1_err", 32'(err), 0);

    // 2. three pushes
    step(PUSH, 5);
    check("t2_tos1", 32'(tos), 5);  check("t2_nos1", 32'(nos), 0); check("t2_cnt1", 32'(count), 1);
    step(PUSH, 7);
    check("t2_tos2", 32'(tos), 7);  check("t2_nos2", 32'(nos), 5); check("t2_cnt2", 32'(count), 2);
    step(PUSH, 9);
    check("t2_tos3", 32'(tos), 9);  check("t2_nos3", 32'(nos), 7); check("t2_cnt3", 32'(count), 3);

    // 3. binop write-back then pop
    step(BINOP, 16);
    check("t3_tos", 32'(tos), 16); check("t3_nos", 32'(nos), 5); check("t3_cnt", 32'(count), 2);
    step(POP, 0);
    check("t3_pop_tos", 32'(tos), 5); check("t3_pop_nos", 32'(nos), 0);
    check("t3_pop_cnt", 32'(count), 1);

    // 4. fill, overflow, drain
    step(NOP, 0, 1'b1);
    for (int i = 1; i <= DEPTH; i++) step(PUSH, WIDTH'(i));
    check("t4_full", 32'(full), 1);
    check("t4_tos", 32'(tos), 32);
    check("t4_nos", 32'(nos), 31);
    step(PUSH, 99);
    check("t4_ovf_err", 32'(err), 1);
    check("t4_ovf_tos", 32'(tos), 32);
    check("t4_ovf_cnt", 32'(count), 32);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      step(POP, 0);
      check("t4_drain_tos", 32'(tos), 32'(i));
    end
    check("t4_empty", 32'(empty), 1);

    // 5. underflow cases
    step(POP, 0);
    check("t5_pop_err", 32'(err), 1);
    check("t5_pop_cnt", 32'(count), 0);
    step(NOP, 0, 1'b1);
    step(PUSH, 4);
    step(BINOP, 1);
    check("t5_bin_err", 32'(err), 1);
    check("t5_bin_tos", 32'(tos), 4);
    check("t5_bin_cnt", 32'(count), 1);

    // 6. reset wins over a concurrent push
    step(NOP, 0, 1'b1);
    step(PUSH, 1); step(PUSH, 2); step(PUSH, 3);
    step(PUSH, 4, 1'b1);
    check("t6_cnt", 32'(count), 0);
    check("t6_tos", 32'(tos), 0);
    check("t6_err", 32'(err), 0);
    step(PUSH, 8);
    check("t6_tos8", 32'(tos), 8);
    check("t6_nos8", 32'(nos), 0);

    // Randomized traffic with phase-varying push bias to reach both ends.
    push_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        case ($urandom_range(2))
          0:       push_pct = 20;
          1:       push_pct = 50;
          default: push_pct = 85;
        endcase
      end
      if ($urandom_range(299) == 0) begin
        step(logic'($urandom_range(3)) ? PUSH : NOP, WIDTH'($urandom), 1'b1);
      end else begin
        x = $urandom_range(99);
        if (x < 8)
          step(NOP, WIDTH'($urandom));
        else if (x < 8 + (push_pct * 92) / 100)
          step(PUSH, WIDTH'($urandom));
        else
          step($urandom_range(1) ? POP : BINOP, WIDTH'($urandom));
      end
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
